quad_encoder_gen: RTL
=====================

// Module: quad_encoder_gen
// PURPOSE
//   Quadrature signal generator: the transmit side of the rotary-encoder interface.
//   Accepts step commands and drives A/B phase outputs with a programmable edge spacing.
//   Optionally emulates contact bounce on each edge.
//   Drives the debounce -> encoder chain in loopback self-test, and acts as an encoder
//   emulator on boards without knobs.
// PARAMETERS
//   WIDTH       8   width of cmd_steps and position
//   DIV_WIDTH   16  width of step_period (clk cycles between edges)
//   BOUNCE_LEN  3   glitch repeats per edge; only used when QENC_BOUNCE_EN is defined
// PORTS
//   clk          in   1          block clock
//   reset        in   1          asynchronous, active-high reset
//   cmd_valid    in   1          command offered
//   cmd_ready    out  1          command accepted when cmd_valid & cmd_ready on a rising clk
//   cmd_dir      in   1          1 = CW (position +1 per edge), 0 = CCW (-1 per edge)
//   cmd_steps    in   WIDTH      number of phase transitions (edges) to emit
//   step_period  in   DIV_WIDTH  clk cycles per edge; 0 is treated as 1
//   a            out  1          quadrature phase A
//   b            out  1          quadrature phase B
//   busy         out  1          command in progress
//   position     out  WIDTH      running signed edge count, modulo 2^WIDTH
// BEHAVIOUR
//   Reset (async, any time, incl. mid-command): a=0, b=0, position=0, busy=0, state IDLE.
//     cmd_ready=1 from the first clk after reset releases. An in-flight command is
//     discarded; no partial completion.
//   FSM: IDLE -> RUN -> IDLE. cmd_ready = (state==IDLE), combinational from state.
//   IDLE: on cmd_valid & cmd_ready, latch dir, steps, P=max(step_period,1).
//     steps==0: command consumed, no edges, stay IDLE, busy stays 0.
//     steps>0: go to RUN, busy=1 next cycle, load period counter with P.
//   RUN: counter decrements each clk. When it expires, the {a,b} phase advances one
//     state and position updates; the counter then reloads P.
//     Edge k (k=1..steps) appears on a/b exactly k*P clks after the accept edge.
//   Phase order {a,b}: CW 00->10->11->01->00; CCW is the reverse.
//     Downstream encoder counts 00->10 and 11->01 as +1, so 2 CW edges = +1 count.
//   Final edge: the clk that registers the last a/b change also sets busy=0 and
//     state=IDLE. cmd_ready=1 that same cycle, so back-to-back commands have no gap
//     beyond P.
//   cmd_valid while busy: ignored. Inputs are not sampled; the latched command is unaffected.
//   Phase is held between commands (never re-homed to 00 except by reset).
//   position wraps modulo 2^WIDTH (0 - 1 = 2^WIDTH-1). Counters never overflow:
//     steps is WIDTH bits, period is DIV_WIDTH bits.
//   a/b are registered, glitch-free when bounce is disabled; all outputs are registered
//     except cmd_ready.
// CONFIGURATION
//   QENC_BOUNCE_EN defined:
//     - At each edge, the changing line takes its new value, then reverts for 1 clk,
//       BOUNCE_LEN times: new,old,new,old,...,new.
//     - Total settle time is 2*BOUNCE_LEN-1 clks from the nominal edge time; the line
//       then holds stable. The non-changing line never glitches.
//     - Bounce time is counted inside P. Requires P >= 2*BOUNCE_LEN; smaller P is
//       forced up to 2*BOUNCE_LEN.
//     - position, busy and cmd_ready timing are identical to the clean build;
//       position updates at the first (nominal) transition.
//   QENC_BOUNCE_EN undefined: single clean transition per edge; BOUNCE_LEN unused;
//     no bounce logic synthesised.
// TESTING
//   1 Reset pulse mid-run -> a=0, b=0, position=0, busy=0; cmd_ready=1 on the next clk.
//   2 From 00: dir=1, steps=4, P=3 -> {a,b} = 10,11,01,00 at +3,+6,+9,+12 clks after
//     accept; position=4; busy falls and cmd_ready rises at +12.
//   3 From 00, position=0: dir=0, steps=2, P=0 -> {a,b} = 01 at +1, 11 at +2;
//     position=255 then 254 (WIDTH=8).
//   4 steps=0 accepted -> no a/b change, busy never asserts, cmd_ready stays 1.
//     cmd_valid pulsed with new values during a busy command -> ignored; the original
//     command completes unchanged.
//   5 Back-to-back: second command held valid during first -> accepted on the cycle of
//     the final edge; its first edge follows P clks later.
//   6 Loopback into debounce(HIST_LEN=8) + encoder(WIDTH=8) on same clk: 8 CW edges,
//     P=64 -> encoder value +4, then 8 CCW edges -> back to start.
//     Repeat with QENC_BOUNCE_EN, BOUNCE_LEN=3 -> identical counts, and glitches are
//     observed on a/b.

Source files
------------

// File: rtl/quad_encoder_gen.sv
// -----------------------------------------------------------------------------
// quad_encoder_gen
//   Quadrature signal generator, the transmit side of a rotary-encoder link.
//   It accepts step commands and drives the A/B phase outputs. Consecutive edges
//   are separated by a programmable number of clk cycles. Typical uses are
//   loopback self-test of a debounce/encoder chain, or standing in for a
//   physical rotary encoder on boards that lack one.
//
//   Optional feature macro: QENC_BOUNCE_EN
//     When defined, each edge on the changing line is followed by contact-bounce
//     glitches: new,old,new,...,new over 2*BOUNCE_LEN-1 clks. The edge period is
//     floored at 2*BOUNCE_LEN so that the bounce always settles inside one period.
//     When undefined, each edge is a single clean transition.
//
// Parameters
//   WIDTH       width of cmd_steps and position
//   DIV_WIDTH   width of step_period
//   BOUNCE_LEN  glitch repeats per edge (bounce build only)
//
// Ports
//   clk          in   block clock
//   reset        in   asynchronous, active-high reset
//   cmd_valid    in   command offered
//   cmd_ready    out  high while idle (combinational from state)
//   cmd_dir      in   1 = CW (+1 per edge), 0 = CCW (-1 per edge)
//   cmd_steps    in   number of edges to emit (0 = consume and do nothing)
//   step_period  in   clk cycles per edge, 0 treated as 1
//   a, b         out  quadrature phases (registered)
//   busy         out  command in progress (registered)
//   position     out  running signed edge count, modulo 2^WIDTH (registered)
// -----------------------------------------------------------------------------
module quad_encoder_gen #(
    parameter int WIDTH      = 8,
    parameter int DIV_WIDTH  = 16,
    parameter int BOUNCE_LEN = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_dir,
    input  logic [WIDTH-1:0]     cmd_steps,
    input  logic [DIV_WIDTH-1:0] step_period,
    output logic                 a,
    output logic                 b,
    output logic                 busy,
    output logic [WIDTH-1:0]     position
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

`ifdef QENC_BOUNCE_EN
    localparam logic [DIV_WIDTH-1:0] P_MIN = DIV_WIDTH'(2 * BOUNCE_LEN);
`else
    // BOUNCE_LEN has no effect in the clean build.
    localparam logic [DIV_WIDTH-1:0] P_MIN = DIV_WIDTH'(1 + 0 * BOUNCE_LEN);
`endif

    logic [0:0]           state;
    logic [DIV_WIDTH-1:0] cnt;        // clks left until the next edge
    logic [DIV_WIDTH-1:0] per_q;      // latched effective period
    logic [WIDTH-1:0]     rem;        // edges still to emit
    logic                 dir_q;
    logic                 pa, pb;     // clean (nominal) phase
    logic [DIV_WIDTH-1:0] period_eff;
    logic                 adv;        // an edge is registered this clk
    logic                 last;       // ...and it is the final one
    logic                 na, nb;     // next phase in the latched direction

    // Handshake: a command transfers on a rising clk where cmd_valid and
    // cmd_ready are both high. cmd_ready is high exactly while idle. While a
    // command runs, the cmd_* inputs are not sampled at all.
    assign cmd_ready  = (state == ST_IDLE);

    assign period_eff = (step_period < P_MIN) ? P_MIN : step_period;
    assign adv        = (state == ST_RUN) && (cnt == DIV_WIDTH'(1));
    assign last       = adv && (rem == WIDTH'(1));

    // CW walks 00->10->11->01->00. CCW walks the same ring backwards.
    assign na = dir_q ? ~pb : pb;
    assign nb = dir_q ? pa  : ~pa;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            per_q    <= '0;
            rem      <= '0;
            dir_q    <= 1'b0;
            pa       <= 1'b0;
            pb       <= 1'b0;
            busy     <= 1'b0;
            position <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // A zero-step command is consumed here without leaving IDLE.
                    if (cmd_valid && (cmd_steps != '0)) begin
                        dir_q <= cmd_dir;
                        per_q <= period_eff;
                        cnt   <= period_eff;
                        rem   <= cmd_steps;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (adv) begin
                        pa       <= na;
                        pb       <= nb;
                        position <= dir_q ? (position + WIDTH'(1)) : (position - WIDTH'(1));
                        cnt      <= per_q;
                        rem      <= rem - WIDTH'(1);
                        // Returning to IDLE on the final edge lets a waiting
                        // command be accepted on the very next clk.
                        if (last) begin
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end
                    end else begin
                        cnt <= cnt - DIV_WIDTH'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef QENC_BOUNCE_EN
    localparam int BW = $clog2(2 * BOUNCE_LEN) + 1;

    logic [BW-1:0] bcnt;     // remaining glitch clks after the nominal edge
    logic          bsel_b;   // 1 when line B is the one that changed
    logic          a_q, b_q;

    // The nominal edge loads the new value. Each following clk toggles the
    // changing line until bcnt runs out. The toggle count is even, so the line
    // finishes on the new value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcnt   <= '0;
            bsel_b <= 1'b0;
            a_q    <= 1'b0;
            b_q    <= 1'b0;
        end else if (adv) begin
            a_q    <= na;
            b_q    <= nb;
            bsel_b <= (nb != pb);
            bcnt   <= BW'(2 * BOUNCE_LEN - 2);
        end else if (bcnt != '0) begin
            if (bsel_b) b_q <= ~b_q;
            else        a_q <= ~a_q;
            bcnt <= bcnt - BW'(1);
        end
    end

    assign a = a_q;
    assign b = b_q;
`else
    assign a = pa;
    assign b = pb;
`endif

endmodule
